cp_remove_ctrl: RTL

CP_REMOVE_CTRL -- requirements
Module: cp_remove_ctrl

---
 rtl/ofdm_rx_pkg.sv | 18 +
 rtl/cp_remove_ctrl_bit_rev.sv | 19 +
 rtl/cp_remove_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receiver defaults (FFT size, sample width, CP length) and the CP-removal FSM state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ofdm_rx_pkg;

  localparam int N_DEF      = 64;
  localparam int LOG2N_DEF  = 6;
  localparam int Q_DEF      = 16;
  localparam int CP_LEN_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP_CP = 2'd1,
    ST_WRITE   = 2'd2,
    ST_READ    = 2'd3
  } cp_state_e;

endpackage

// File: rtl/cp_remove_ctrl_bit_rev.sv
// Bit-reversal of an LOG2N-bit address, used to present buffer reads in radix-2 DIT input order.
// Latency: combinational.
// Backpressure: not applicable.
module bit_rev #(
  parameter int LOG2N = 6
) (
  input  logic [LOG2N-1:0] in_addr,
  output logic [LOG2N-1:0] out_addr
);

  // Mirror bit i onto bit LOG2N-1-i.
  always_comb begin
    out_addr = '0;
    for (int b = 0; b < LOG2N; b++) begin
      out_addr[b] = in_addr[LOG2N-1-b];
    end
  end

endmodule

// File: rtl/cp_remove_ctrl.sv
// Cyclic-prefix removal: drops CP_LEN prefix samples, writes N body samples to a buffer, then reads them out.
// Latency: writes are combinational with the accepted sample; rd_valid follows each addrb by one cycle.
// Backpressure: in_ready low for the N read cycles (samples dropped); optional BIT_REVERSE_EN reverses addrb.
module cp_remove_ctrl
  import ofdm_rx_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LOG2N  = LOG2N_DEF,
  parameter int Q      = Q_DEF,
  parameter int CP_LEN = CP_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_start,
  input  logic             in_valid,
  input  logic [Q-1:0]     in_r,
  input  logic [Q-1:0]     in_i,
  output logic             in_ready,
  output logic [LOG2N-1:0] addra,
  output logic             we,
  output logic [Q-1:0]     data_r,
  output logic [Q-1:0]     data_i,
  output logic [LOG2N-1:0] addrb,
  output logic             rd_valid,
  output logic             sym_done
);

  // One spare bit so the counter never wraps before its terminal compare.
  localparam int              CW       = LOG2N + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]   CP_LAST  = CW'(CP_LEN - 1);

  cp_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             rd_valid_q;
  logic             sym_done_q;

  logic             accept;
  logic             restart;
  logic [LOG2N-1:0] rd_idx;

  assign in_ready = (state_q != ST_READ);
  assign accept   = in_valid & in_ready;
  // A new symbol start is honoured everywhere except while the buffer is being read.
  assign restart  = sym_start & (state_q != ST_READ);

  // Control FSM: counts prefix, body and read cycles; registers rd_valid/sym_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      sym_done_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == ST_READ);
      sym_done_q <= (state_q == ST_READ) && (cnt_q == CNT_LAST);
      if (restart) begin
        // The sample arriving with sym_start is prefix sample 0.
        if (accept && (CP_LEN == 1)) begin
          state_q <= ST_WRITE;
          cnt_q   <= '0;
        end else begin
          state_q <= ST_SKIP_CP;
          cnt_q   <= accept ? CW'(1) : '0;
        end
      end else begin
        case (state_q)
          ST_SKIP_CP: begin
            if (accept) begin
              if (cnt_q == CP_LAST) begin
                state_q <= ST_WRITE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          ST_WRITE: begin
            if (accept) begin
              if (cnt_q == CNT_LAST) begin
                state_q <= ST_READ;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          ST_READ: begin
            // Leave READ after issuing the last address so IDLE overlaps the final rd_valid.
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Write port is driven straight from the input sample; a restart sample is never written.
  assign we     = (state_q == ST_WRITE) & in_valid & ~sym_start;
  assign addra  = (state_q == ST_WRITE) ? cnt_q[LOG2N-1:0] : '0;
  assign data_r = we ? in_r : '0;
  assign data_i = we ? in_i : '0;

  assign rd_idx = (state_q == ST_READ) ? cnt_q[LOG2N-1:0] : '0;

`ifdef BIT_REVERSE_EN
  bit_rev #(
    .LOG2N(LOG2N)
  ) u_bit_rev (
    .in_addr (rd_idx),
    .out_addr(addrb)
  );
`else
  assign addrb = rd_idx;
`endif

  assign rd_valid = rd_valid_q;
  assign sym_done = sym_done_q;

endmodule
